instruction_decode: RTL and testbench

Decode stage of the 4-stage 8-bit pipeline (IF, ID, EX, WB), directly downstream of instruction fetch. It captures the fetched instruction and PC in the IF/ID register and decodes the instruction. It reads a 4x8 register file that is written from WB, then registers the operands and control into the ID/EX register for execute. It honours the active-low flush pulses that fetch raises on a taken jump, and flags the EX-to-ID forwarding that EX must apply.

---
 rtl/instruction_decode.sv | 182 ++++++++++++++++++
 tb/tb_instruction_decode.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// Decode stage of the 4-stage 8-bit pipeline: IF/ID register, 4x8 register file
// with write-back bypass, instruction decode and the ID/EX register with forwarding flags.
module instruction_decode #(
    parameter int         NUM_REGS = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Instruction_Code,
    input  logic [7:0] PC_in,
    input  logic       reset_IFID,
    input  logic       reset_IDEX,
    input  logic       wb_en,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data,
    output logic [3:0] op_EX,
    output logic [7:0] opA_EX,
    output logic [7:0] opB_EX,
    output logic [1:0] rd_EX,
    output logic       we_EX,
    output logic       jump_EX,
    output logic [7:0] pc_EX,
    output logic       valid_EX,
    output logic       fwdA_EX,
    output logic       fwdB_EX,
    output logic       illegal_EX
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_MOV  = 4'h6,
        OP_ADDI = 4'h7,
        OP_JR   = 4'h8
    } opcode_e;

    logic [7:0] r_rf [NUM_REGS];
    logic [7:0] r_ifid_instr;
    logic [7:0] r_ifid_pc;
    logic       r_ifid_valid;

    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic [7:0] w_rd_val;
    logic [7:0] w_rs_val;
    logic [3:0] w_op;
    logic [7:0] w_opa;
    logic [7:0] w_opb;
    logic       w_we;
    logic       w_jump;
    logic       w_illegal;
    logic       w_src_a;
    logic       w_src_b;
    logic       w_fwd_a;
    logic       w_fwd_b;

    assign w_rd = r_ifid_instr[3:2];
    assign w_rs = r_ifid_instr[1:0];

    // A write-back landing this cycle is visible to the instruction being decoded.
    assign w_rd_val = (wb_en && (wb_addr == w_rd)) ? wb_data : r_rf[w_rd];
    assign w_rs_val = (wb_en && (wb_addr == w_rs)) ? wb_data : r_rf[w_rs];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_op      = OP_NOP;
        w_opa     = 8'h00;
        w_opb     = 8'h00;
        w_we      = 1'b0;
        w_jump    = 1'b0;
        w_illegal = 1'b0;
        w_src_a   = 1'b0;
        w_src_b   = 1'b0;
        case (r_ifid_instr[7:4])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                w_op    = r_ifid_instr[7:4];
                w_opa   = w_rd_val;
                w_opb   = w_rs_val;
                w_we    = 1'b1;
                w_src_a = 1'b1;
                w_src_b = 1'b1;
            end
            OP_MOV: begin
                w_op    = OP_MOV;
                w_opb   = w_rs_val;
                w_we    = 1'b1;
                w_src_b = 1'b1;
            end
            OP_ADDI: begin
                w_op    = OP_ADDI;
                w_opa   = w_rd_val;
                w_opb   = {6'b0, w_rs};
                w_we    = 1'b1;
                w_src_a = 1'b1;
            end
            OP_JR: begin
                w_op    = OP_JR;
                w_opa   = w_rd_val;
                w_jump  = 1'b1;
                w_src_a = 1'b1;
            end
            OP_NOP:  ;
            default: w_illegal = 1'b1;
        endcase
    end

    // Forwarding compares against the instruction currently in ID/EX, one ahead of this one.
    assign w_fwd_a = r_ifid_valid && w_src_a && valid_EX && we_EX && (rd_EX == w_rd);
    assign w_fwd_b = r_ifid_valid && w_src_b && valid_EX && we_EX && (rd_EX == w_rs);

    // NOTE: the register file is reset explicitly because software may read it before any write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= 8'h00;
            end
        end else if (wb_en) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifid_instr <= 8'h00;
            r_ifid_pc    <= RESET_PC;
            r_ifid_valid <= 1'b0;
        end else begin
            r_ifid_pc <= PC_in;
            if (!reset_IFID) begin
                r_ifid_instr <= 8'h00;
                r_ifid_valid <= 1'b0;
            end else begin
                r_ifid_instr <= Instruction_Code;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_EX      <= 4'h0;
            opA_EX     <= 8'h00;
            opB_EX     <= 8'h00;
            rd_EX      <= 2'd0;
            pc_EX      <= RESET_PC;
            valid_EX   <= 1'b0;
            we_EX      <= 1'b0;
            jump_EX    <= 1'b0;
            illegal_EX <= 1'b0;
            fwdA_EX    <= 1'b0;
            fwdB_EX    <= 1'b0;
        end else begin
            op_EX  <= w_op;
            opA_EX <= w_opa;
            opB_EX <= w_opb;
            rd_EX  <= w_rd;
            pc_EX  <= r_ifid_pc;
            // A flush only has to kill the control fields; data is ignored once valid_EX drops.
            if (!reset_IDEX) begin
                valid_EX   <= 1'b0;
                we_EX      <= 1'b0;
                jump_EX    <= 1'b0;
                illegal_EX <= 1'b0;
                fwdA_EX    <= 1'b0;
                fwdB_EX    <= 1'b0;
            end else begin
                valid_EX   <= r_ifid_valid;
                we_EX      <= r_ifid_valid && w_we;
                jump_EX    <= r_ifid_valid && w_jump;
                illegal_EX <= r_ifid_valid && w_illegal;
                fwdA_EX    <= w_fwd_a;
                fwdB_EX    <= w_fwd_b;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed scenarios plus random
// stimulus compared against an instruction-level reference model.
module tb_instruction_decode;

    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       jump;
        logic       illegal;
        logic       fwda;
        logic       fwdb;
        logic [3:0] op;
        logic [1:0] rd;
        logic [7:0] pc;
        logic [7:0] opa;
        logic [7:0] opb;
    } ex_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] Instruction_Code;
    logic [7:0] PC_in;
    logic       reset_IFID;
    logic       reset_IDEX;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic [3:0] op_EX;
    logic [7:0] opA_EX;
    logic [7:0] opB_EX;
    logic [1:0] rd_EX;
    logic       we_EX;
    logic       jump_EX;
    logic [7:0] pc_EX;
    logic       valid_EX;
    logic       fwdA_EX;
    logic       fwdB_EX;
    logic       illegal_EX;

    int errors = 0;
    int checks = 0;

    // Reference model state: architectural registers, the fetched-but-undecoded
    // instruction, and the expected execute word with which of its operands matter.
    logic [7:0] m_rf [4];
    logic [7:0] m_if_ins;
    logic [7:0] m_if_pc;
    logic       m_if_v;
    ex_t        m_ex;
    logic       m_use_a;
    logic       m_use_b;

    instruction_decode #(.NUM_REGS(4), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .Instruction_Code (Instruction_Code),
        .PC_in            (PC_in),
        .reset_IFID       (reset_IFID),
        .reset_IDEX       (reset_IDEX),
        .wb_en            (wb_en),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .op_EX            (op_EX),
        .opA_EX           (opA_EX),
        .opB_EX           (opB_EX),
        .rd_EX            (rd_EX),
        .we_EX            (we_EX),
        .jump_EX          (jump_EX),
        .pc_EX            (pc_EX),
        .valid_EX         (valid_EX),
        .fwdA_EX          (fwdA_EX),
        .fwdB_EX          (fwdB_EX),
        .illegal_EX       (illegal_EX)
    );

    always #5 clk = ~clk;

    function automatic ex_t raw_obs();
        ex_t o;
        o.valid   = valid_EX;
        o.we      = we_EX;
        o.jump    = jump_EX;
        o.illegal = illegal_EX;
        o.fwda    = fwdA_EX;
        o.fwdb    = fwdB_EX;
        o.op      = op_EX;
        o.rd      = rd_EX;
        o.pc      = pc_EX;
        o.opa     = opA_EX;
        o.opb     = opB_EX;
        return o;
    endfunction

    // DUT word with the fields the model treats as don't-care cleared.
    function automatic ex_t observe();
        ex_t o;
        o = raw_obs();
        if (!m_ex.valid) begin
            o.rd = 2'd0;
            o.pc = 8'h00;
        end
        if (!m_ex.valid || m_ex.illegal) o.op = 4'h0;
        if (!m_use_a) o.opa = 8'h00;
        if (!m_use_b) o.opb = 8'h00;
        return o;
    endfunction

    function automatic logic [7:0] rf_read(input logic [1:0] idx, input logic wbe,
                                           input logic [1:0] wba, input logic [7:0] wbd);
        return (wbe && wba == idx) ? wbd : m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_if_ins = 8'h00;
        m_if_pc  = RESET_PC;
        m_if_v   = 1'b0;
        m_ex     = '0;
        m_ex.pc  = RESET_PC;
        m_use_a  = 1'b0;
        m_use_b  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance through the posedge, update the model, settle 1 time unit.
    task automatic step(input logic [7:0] ins, input logic [7:0] pc, input logic fi, input logic fe,
                        input logic wbe, input logic [1:0] wba, input logic [7:0] wbd);
        ex_t        nx;
        logic       ua, ub, sa, sb;
        logic [3:0] op;
        logic [1:0] rd, rs;
        Instruction_Code = ins;
        PC_in            = pc;
        reset_IFID       = fi;
        reset_IDEX       = fe;
        wb_en            = wbe;
        wb_addr          = wba;
        wb_data          = wbd;
        op = m_if_ins[7:4];
        rd = m_if_ins[3:2];
        rs = m_if_ins[1:0];
        nx = '0;
        ua = 1'b0; ub = 1'b0; sa = 1'b0; sb = 1'b0;
        if (fe && m_if_v) begin
            nx.valid = 1'b1;
            nx.rd    = rd;
            nx.pc    = m_if_pc;
            if (op >= 4'd1 && op <= 4'd5) begin
                nx.op = op; nx.we = 1'b1;
                nx.opa = rf_read(rd, wbe, wba, wbd);
                nx.opb = rf_read(rs, wbe, wba, wbd);
                ua = 1'b1; ub = 1'b1; sa = 1'b1; sb = 1'b1;
            end else if (op == 4'd6) begin
                nx.op = op; nx.we = 1'b1;
                nx.opa = 8'h00;
                nx.opb = rf_read(rs, wbe, wba, wbd);
                ua = 1'b1; ub = 1'b1; sb = 1'b1;
            end else if (op == 4'd7) begin
                nx.op = op; nx.we = 1'b1;
                nx.opa = rf_read(rd, wbe, wba, wbd);
                nx.opb = {6'b0, rs};
                ua = 1'b1; ub = 1'b1; sa = 1'b1;
            end else if (op == 4'd8) begin
                nx.op = op; nx.jump = 1'b1;
                nx.opa = rf_read(rd, wbe, wba, wbd);
                ua = 1'b1; sa = 1'b1;
            end else if (op != 4'd0) begin
                nx.illegal = 1'b1;
            end
            nx.fwda = sa && m_ex.valid && m_ex.we && (m_ex.rd == rd);
            nx.fwdb = sb && m_ex.valid && m_ex.we && (m_ex.rd == rs);
        end
        @(posedge clk);
        m_ex    = nx;
        m_use_a = ua;
        m_use_b = ub;
        if (wbe) m_rf[wba] = wbd;
        m_if_ins = fi ? ins : 8'h00;
        m_if_v   = fi;
        m_if_pc  = pc;
        #1;
    endtask

    task automatic nop(input logic [7:0] pc);
        step(8'h00, pc, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic test_reset();
        ex_t rv;
        rv    = '0;
        rv.pc = RESET_PC;
        rst_n = 1'b0;
        Instruction_Code = 8'h00; PC_in = 8'h00;
        reset_IFID = 1'b1; reset_IDEX = 1'b1;
        wb_en = 1'b0; wb_addr = 2'd0; wb_data = 8'h00;
        model_reset();
        #2;
        checks++;
        if (raw_obs() !== rv) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", raw_obs(), rv);
        end
        Instruction_Code = 8'h16; PC_in = 8'h44; wb_en = 1'b1; wb_data = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (raw_obs() !== rv) begin
            errors++;
            $display("FAIL reset_held got=%h exp=%h", raw_obs(), rv);
        end
        @(negedge clk);
        wb_en = 1'b0;
        rst_n = 1'b1;
        nop(8'h01);
        checks++;
        if (raw_obs() !== rv) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", raw_obs(), rv);
        end
        for (int k = 0; k < 4; k++) step({6'b011000, 2'(k)}, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            step({6'b011000, 2'(k)}, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
            checks++;
            if (opB_EX !== 8'h00 || valid_EX !== 1'b1) begin
                errors++;
                $display("FAIL rf_zero_r%0d got opB=%h valid=%b exp opB=00 valid=1", k, opB_EX, valid_EX);
            end
        end
    endtask

    task automatic test_add();
        step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 2'd1, 8'h05);
        step(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 2'd2, 8'h03);
        step(8'h16, 8'h10, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        nop(8'h11);
        checks++;
        if ({op_EX, opA_EX, opB_EX, rd_EX, we_EX, pc_EX, valid_EX, fwdA_EX, fwdB_EX}
            !== {4'h1, 8'h05, 8'h03, 2'd1, 1'b1, 8'h10, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL add_basic got op=%h A=%h B=%h rd=%0d we=%b pc=%h v=%b fA=%b fB=%b exp op=1 A=05 B=03 rd=1 we=1 pc=10 v=1 fA=0 fB=0",
                     op_EX, opA_EX, opB_EX, rd_EX, we_EX, pc_EX, valid_EX, fwdA_EX, fwdB_EX);
        end
    endtask

    task automatic test_forwarding();
        step(8'h16, 8'h20, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        step(8'h2D, 8'h21, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        nop(8'h22);
        checks++;
        if ({op_EX, fwdA_EX, fwdB_EX, opB_EX} !== {4'h2, 1'b0, 1'b1, 8'h05}) begin
            errors++;
            $display("FAIL fwd_sub got op=%h fA=%b fB=%b B=%h exp op=2 fA=0 fB=1 B=05", op_EX, fwdA_EX, fwdB_EX, opB_EX);
        end
        step(8'h16, 8'h30, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        step(8'h76, 8'h31, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        nop(8'h32);
        checks++;
        if ({op_EX, fwdA_EX, fwdB_EX, opA_EX, opB_EX} !== {4'h7, 1'b1, 1'b0, 8'h05, 8'h02}) begin
            errors++;
            $display("FAIL fwd_addi got op=%h fA=%b fB=%b A=%h B=%h exp op=7 fA=1 fB=0 A=05 B=02",
                     op_EX, fwdA_EX, fwdB_EX, opA_EX, opB_EX);
        end
    endtask

    task automatic test_wb_bypass();
        step(8'h62, 8'h40, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        step(8'h00, 8'h41, 1'b1, 1'b1, 1'b1, 2'd2, 8'hAA);
        checks++;
        if ({op_EX, opA_EX, opB_EX, we_EX} !== {4'h6, 8'h00, 8'hAA, 1'b1}) begin
            errors++;
            $display("FAIL wb_bypass got op=%h A=%h B=%h we=%b exp op=6 A=00 B=aa we=1", op_EX, opA_EX, opB_EX, we_EX);
        end
    endtask

    task automatic test_flush();
        step(8'h8C, 8'h50, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        step(8'h00, 8'h51, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        checks++;
        if ({valid_EX, we_EX, jump_EX} !== 3'b000) begin
            errors++;
            $display("FAIL flush_bubble1 got v/we/j=%b exp 000", {valid_EX, we_EX, jump_EX});
        end
        step(8'h21, 8'h52, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        checks++;
        if ({valid_EX, we_EX, jump_EX} !== 3'b000) begin
            errors++;
            $display("FAIL flush_bubble2 got v/we/j=%b exp 000", {valid_EX, we_EX, jump_EX});
        end
        nop(8'h53);
        checks++;
        if ({op_EX, valid_EX, we_EX, jump_EX, pc_EX, opA_EX, opB_EX, fwdA_EX, fwdB_EX}
            !== {4'h2, 3'b110, 8'h52, 8'h00, 8'h05, 2'b00}) begin
            errors++;
            $display("FAIL flush_resume got op=%h v=%b we=%b j=%b pc=%h A=%h B=%h exp op=2 v=1 we=1 j=0 pc=52 A=00 B=05",
                     op_EX, valid_EX, we_EX, jump_EX, pc_EX, opA_EX, opB_EX);
        end
    endtask

    task automatic test_illegal();
        step(8'hF0, 8'h60, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        nop(8'h61);
        checks++;
        if ({valid_EX, illegal_EX, we_EX, jump_EX} !== 4'b1100) begin
            errors++;
            $display("FAIL illegal got v/ill/we/j=%b exp 1100", {valid_EX, illegal_EX, we_EX, jump_EX});
        end
    endtask

    task automatic test_random(input int n);
        ex_t got;
        for (int i = 0; i < n; i++) begin
            step(8'($urandom), 8'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 2) == 0), 2'($urandom), 8'($urandom));
            got = observe();
            checks++;
            if (got !== m_ex) begin
                errors++;
                $display("FAIL random_%0d got=%h exp=%h", i, got, m_ex);
            end
        end
    endtask

    task automatic test_mid_reset();
        ex_t rv;
        ex_t got;
        rv    = '0;
        rv.pc = RESET_PC;
        test_random(20);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (raw_obs() !== rv) begin
            errors++;
            $display("FAIL mid_reset_async got=%h exp=%h", raw_obs(), rv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step({6'b011000, 2'(k)}, 8'h70, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
            got = observe();
            checks++;
            if (got !== m_ex) begin
                errors++;
                $display("FAIL post_reset_%0d got=%h exp=%h", k, got, m_ex);
            end
        end
        test_random(40);
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_wb_bypass();
        test_flush();
        test_illegal();
        test_random(400);
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
